fir_mac: RTL and testbench

FIR_MAC -- requirements
Module: fir_mac

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_delay_line.sv | 41 ++++
 rtl/fir_mac.sv | 121 ++++++++++++
 tb/tb_fir_mac.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state encoding and output saturation for the FIR MAC
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_NTAPS  = 32;
    localparam int DEF_OUT_W  = 32;
    localparam int SAT_W      = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // Clamp a sign-extended value into the signed range of out_w bits
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                         input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample buffer, one write port and an indexed read of x[n-k]
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int AW     = $clog2(NTAPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic [AW-1:0]            k_i,
    output logic signed [DATA_W-1:0] data_o
);

    logic signed [DATA_W-1:0] mem_q [NTAPS];
    logic [AW-1:0]            wptr_q;
    logic [AW-1:0]            wptr_d;
    logic [AW-1:0]            rd_idx;
    logic [AW:0]              rd_sum;

    assign wptr_d = (wptr_q == AW'(NTAPS - 1)) ? '0 : wptr_q + AW'(1);

    // The newest sample sits one slot behind the write pointer; step back k more, modulo NTAPS
    assign rd_sum = {1'b0, wptr_q} + (AW+1)'(NTAPS - 1) - {1'b0, k_i};
    assign rd_idx = (rd_sum >= (AW+1)'(NTAPS)) ? AW'(rd_sum - (AW+1)'(NTAPS)) : AW'(rd_sum);
    assign data_o = mem_q[rd_idx];

    // Store an accepted sample and advance the write pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
            wptr_q <= '0;
        end else if (we_i) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_d;
        end
    end

endmodule

// File: rtl/fir_mac.sv
// fir_mac: FIR filter with one time-multiplexed multiplier and saturated output
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int OUT_W  = DEF_OUT_W,
    localparam int AW    = $clog2(NTAPS),
    localparam int ACC_W = DATA_W + COEF_W + AW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic signed [DATA_W-1:0] data_i,
    output logic                     valid_o,
    output logic signed [OUT_W-1:0]  data_o,
    input  logic                     coef_we_i,
    input  logic [AW-1:0]            coef_addr_i,
    input  logic signed [COEF_W-1:0] coef_data_i,
    output logic                     coef_err_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    fir_state_e               state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic signed [COEF_W-1:0] coef_q [NTAPS];
    logic signed [DATA_W-1:0] x_k;
    logic signed [COEF_W-1:0] c_k;
    logic signed [PROD_W-1:0] prod;
    logic                     accept;
    logic                     coef_ok;

    assign ready_o    = (state_q == IDLE);
    assign accept     = valid_i && ready_o;
    assign coef_ok    = coef_we_i && ready_o && (32'(coef_addr_i) < NTAPS);
    assign err_d      = coef_we_i && !coef_ok;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign coef_err_o = err_q;

    fir_delay_line #(
        .DATA_W(DATA_W),
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_delay (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we_i  (accept),
        .data_i(data_i),
        .k_i   (k_q),
        .data_o(x_k)
    );

    assign c_k  = coef_q[k_q];
    assign prod = PROD_W'(c_k) * PROD_W'(x_k);

    // Sequence one sample: accept in IDLE, NTAPS multiply-accumulate steps, then publish
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = (k_q == AW'(NTAPS - 1)) ? '0 : k_q + AW'(1);
                if (k_q == AW'(NTAPS - 1)) state_d = DONE;
            end
            DONE: begin
                data_d  = OUT_W'(saturate(SAT_W'(acc_q), OUT_W));
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset abandons any computation in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Coefficient table, writable only while idle and in range
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else if (coef_ok) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: directed checks of the FIR MAC against hand values and a reference FIR
module tb_fir_mac;

    localparam logic signed [63:0] YMAX = 64'sd2147483647;
    localparam logic signed [63:0] YMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_i = 1'b0;
    logic               ready_o;
    logic signed [15:0] data_i = '0;
    logic               valid_o;
    logic signed [31:0] data_o;
    logic               coef_we = 1'b0;
    logic [4:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               coef_err_o;

    logic               ready30, valid30_o, err30;
    logic signed [31:0] data30_o;
    logic               we30 = 1'b0;
    logic [4:0]         addr30 = '0;
    logic signed [15:0] cdata30 = '0;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    longint cm [32];
    longint hist [$];
    longint exp_y;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fir_mac dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .coef_we_i  (coef_we),
        .coef_addr_i(coef_addr),
        .coef_data_i(coef_data),
        .coef_err_o (coef_err_o)
    );

    fir_mac #(.NTAPS(30)) dut30 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (1'b0),
        .ready_o    (ready30),
        .data_i     (16'sd0),
        .valid_o    (valid30_o),
        .data_o     (data30_o),
        .coef_we_i  (we30),
        .coef_addr_i(addr30),
        .coef_data_i(cdata30),
        .coef_err_o (err30)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_push(input longint x);
        longint s = 0;
        hist.push_front(x);
        if (hist.size() > 32) void'(hist.pop_back());
        foreach (hist[i]) s += cm[i] * hist[i];
        if (s > YMAX) s = YMAX;
        if (s < YMIN) s = YMIN;
        return s;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        coef_we = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        hist.delete();
        foreach (cm[i]) cm[i] = 0;
    endtask

    task automatic write_coef(input int a, input longint v, input logic exp_err, input string tag);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 16'(v);
        @(negedge clk);
        coef_we = 1'b0;
        check(tag, coef_err_o, exp_err);
        if (!exp_err) cm[a] = v;
    endtask

    task automatic start_sample(input longint x);
        int n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("ready_timeout", ready_o, 1);
        valid_i = 1'b1;
        data_i  = 16'(x);
        @(negedge clk);
        valid_i = 1'b0;
        acc_cyc = cyc;
        exp_y   = model_push(x);
    endtask

    task automatic wait_result(output longint y, output int lat);
        int n = 0;
        while (!valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!valid_o) check("valid_timeout", valid_o, 1);
        y   = data_o;
        lat = cyc - acc_cyc;
    endtask

    initial begin
        longint y;
        int     lat;
        longint expq [$];
        longint cur;
        logic   will;
        int     nacc, last_acc, low, n, seen;
        logic signed [15:0] r;

        do_reset();
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", coef_err_o, 0);

        // impulse response with c[k]=k+1
        for (int k = 0; k < 32; k++) write_coef(k, k + 1, 1'b0, $sformatf("imp_we%0d", k));
        for (int i = 0; i < 41; i++) begin
            start_sample(i == 0 ? 1 : 0);
            wait_result(y, lat);
            check($sformatf("imp_y%0d", i), y, i < 32 ? i + 1 : 0);
            check($sformatf("imp_lat%0d", i), lat, 33);
        end
        @(negedge clk);
        check("valid_one_cycle", valid_o, 0);

        // coefficient write during MAC is rejected
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(k, k + 1, 1'b0, $sformatf("err_we%0d", k));
        start_sample(1);
        write_coef(0, 999, 1'b1, "we_mac_err");
        @(negedge clk);
        check("err_pulse_end", coef_err_o, 0);
        wait_result(y, lat);
        check("mac_we_y0", y, 1);
        start_sample(0);
        wait_result(y, lat);
        check("mac_we_y1", y, 2);

        // out-of-range address on a 30-tap instance
        we30 = 1'b1; addr30 = 5'd31; cdata30 = 16'sd7;
        @(negedge clk);
        we30 = 1'b0;
        check("n30_addr31_err", err30, 1);
        we30 = 1'b1; addr30 = 5'd29;
        @(negedge clk);
        we30 = 1'b0;
        check("n30_addr29_ok", err30, 0);
        we30 = 1'b1; addr30 = 5'd30;
        @(negedge clk);
        we30 = 1'b0;
        check("n30_addr30_err", err30, 1);

        // saturation both ways
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(k, 32767, 1'b0, $sformatf("sat_we%0d", k));
        for (int i = 0; i < 32; i++) begin
            start_sample(32767);
            wait_result(y, lat);
            if (i == 0) check("sat_first", y, 64'sd1073676289);
        end
        check("sat_pos", y, 64'sd2147483647);
        for (int i = 0; i < 32; i++) begin
            start_sample(-32768);
            wait_result(y, lat);
        end
        check("sat_neg", y, -64'sd2147483648);

        // continuous valid_i: one acceptance every 34 cycles
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(k, (k * 37) % 200 - 100, 1'b0, $sformatf("thr_we%0d", k));
        nacc = 0; last_acc = 0; low = 0; n = 0;
        cur = -3500;
        valid_i = 1'b1;
        data_i  = 16'(cur);
        while ((nacc < 8 || expq.size() > 0) && n < 600) begin
            will = ready_o && valid_i;
            @(negedge clk);
            n++;
            if (will) begin
                expq.push_back(model_push(cur));
                if (nacc > 0) begin
                    check("thr_spacing", cyc - last_acc, 34);
                    check("thr_ready_low", low, 33);
                end
                last_acc = cyc;
                low = 0;
                nacc++;
                cur = cur + 1000;
                data_i = 16'(cur);
                if (nacc == 8) valid_i = 1'b0;
            end
            if (!ready_o) low++;
            if (valid_o) begin
                if (expq.size() > 0) check("thr_y", data_o, expq.pop_front());
                else check("thr_spurious", valid_o, 0);
            end
        end
        check("thr_accepted", nacc, 8);
        check("thr_drained", expq.size(), 0);

        // random samples across many pointer wraps
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            r = 16'($urandom());
            start_sample(r);
            wait_result(y, lat);
            check($sformatf("wrap_y%0d", i), y, exp_y);
        end

        // reset at k=10 aborts the computation and clears coefficients
        start_sample(500);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_data", data_o, 0);
        check("rst_mid_ready", ready_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        foreach (cm[i]) cm[i] = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        check("rst_mid_data_hold", data_o, 0);
        for (int i = 0; i < 3; i++) begin
            start_sample(i == 0 ? 1 : 0);
            wait_result(y, lat);
            check($sformatf("rst_imp_y%0d", i), y, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end

endmodule
